// File: rtl/modbus_tx_sched_pkg.sv
// Shared types and timing helpers for the Modbus response scheduler.
// State encoding, one-hot request kinds and character-time arithmetic.
package modbus_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

    typedef logic [2:0] kind_t;

    localparam kind_t KIND_NONE = 3'b000;
    localparam kind_t KIND_0304 = 3'b001;
    localparam kind_t KIND_06   = 3'b010;
    localparam kind_t KIND_EXP  = 3'b100;

    function automatic int unsigned bps_of(
        input int unsigned clk_freq,
        input int unsigned baud
    );
        return clk_freq / baud;
    endfunction

    // One character is 10 bit times on the wire.
    function automatic int unsigned char_cycles(
        input int unsigned chars,
        input int unsigned bps
    );
        return chars * 10 * bps;
    endfunction

    function automatic int unsigned max_u(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/modbus_char_timer.sv
// Loadable down-counter; done pulses in the last enabled cycle of the count.
// A load of N yields done after exactly N enabled cycles.
module modbus_char_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = en && !load && (cnt == W'(1));

endmodule

// File: rtl/modbus_tx_sched.sv
// Modbus response scheduler: inter-frame gap, start pulse, completion wait.
// Define MODBUS_TX_WDOG_EN to abort a response that never completes.
module modbus_tx_sched
    import modbus_tx_sched_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned GAP_CHARS  = 4,
    parameter int unsigned WDOG_CHARS = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_exp,
    input  logic req_06,
    input  logic req_0304,
    input  logic req_bcast,
    input  logic response_done,
    output logic tx_exp_rp_start,
    output logic tx_06_rp_start,
    output logic tx_03_04_rp_start,
    output logic busy,
    output logic sched_done,
    output logic overrun,
    output logic wdog_to
);

    localparam int unsigned BPS      = bps_of(CLK_FREQ, BAUD_RATE);
    localparam int unsigned GAP_CYC  = char_cycles(GAP_CHARS, BPS);
    localparam int unsigned WDOG_CYC = char_cycles(WDOG_CHARS, BPS);
    localparam int          CW       = $clog2(max_u(GAP_CYC, WDOG_CYC)) + 1;
    localparam logic [CW-1:0] GAP_LD = CW'(GAP_CYC);

    state_t state;
    state_t state_nx;
    kind_t  kind_q;
    kind_t  req_kind;
    logic   any_req;
    logic   capture;
    logic   bc_q;
    logic   ovr_q;
    logic   tmr_load;
    logic   tmr_en;
    logic   tmr_done;
    logic   wd_hit;
    logic [CW-1:0] tmr_val;

    assign any_req = req_exp | req_06 | req_0304;
    assign capture = (state == ST_IDLE) && any_req && !req_bcast;

    // Simultaneous pulses are legal, so this must be a priority pick.
    always_comb begin
        req_kind = KIND_NONE;
        priority case (1'b1)
            req_exp:  req_kind = KIND_EXP;
            req_06:   req_kind = KIND_06;
            req_0304: req_kind = KIND_0304;
            default:  req_kind = KIND_NONE;
        endcase
    end

`ifdef MODBUS_TX_WDOG_EN
    localparam logic [CW-1:0] WDOG_LD = CW'(WDOG_CYC);

    assign tmr_load = capture || (state == ST_START);
    assign tmr_en   = (state == ST_GAP) || (state == ST_WAIT);
    assign tmr_val  = (state == ST_IDLE) ? GAP_LD : WDOG_LD;
    assign wd_hit   = (state == ST_WAIT) && tmr_done && !response_done;
`else
    assign tmr_load = capture;
    assign tmr_en   = (state == ST_GAP);
    assign tmr_val  = GAP_LD;
    assign wd_hit   = 1'b0;
`endif

    modbus_char_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            kind_q <= KIND_NONE;
            bc_q   <= 1'b0;
            ovr_q  <= 1'b0;
        end else begin
            state <= state_nx;
            if (capture) begin
                kind_q <= req_kind;
            end
            bc_q  <= (state == ST_IDLE) && any_req && req_bcast;
            ovr_q <= (state != ST_IDLE) && any_req;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (capture) state_nx = ST_GAP;
            ST_GAP:   if (tmr_done) state_nx = ST_START;
            ST_START: state_nx = ST_WAIT;
            ST_WAIT:  if (response_done || wd_hit) state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_exp_rp_start   = (state == ST_START) && kind_q[2];
        tx_06_rp_start    = (state == ST_START) && kind_q[1];
        tx_03_04_rp_start = (state == ST_START) && kind_q[0];
        busy              = (state != ST_IDLE);
        sched_done        = bc_q ||
                            ((state == ST_WAIT) && (response_done || wd_hit));
        overrun           = ovr_q;
        wdog_to           = wd_hit;
    end

endmodule

// File: tb/tb_modbus_tx_sched.sv
// Randomized scoreboard bench for modbus_tx_sched (BPS=10, gap 400, wdog 3200).
// Build with MODBUS_TX_WDOG_EN defined to exercise the watchdog expectations.
module tb_modbus_tx_sched;

    localparam int G  = 4 * 10 * (1000000 / 100000);
    localparam int WD = 32 * 10 * (1000000 / 100000);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_exp = 1'b0;
    logic req_06 = 1'b0;
    logic req_0304 = 1'b0;
    logic req_bcast = 1'b0;
    logic response_done = 1'b0;
    logic tx_exp_rp_start;
    logic tx_06_rp_start;
    logic tx_03_04_rp_start;
    logic busy;
    logic sched_done;
    logic overrun;
    logic wdog_to;

    modbus_tx_sched #(
        .CLK_FREQ   (1000000),
        .BAUD_RATE  (100000),
        .GAP_CHARS  (4),
        .WDOG_CHARS (32)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_exp           (req_exp),
        .req_06            (req_06),
        .req_0304          (req_0304),
        .req_bcast         (req_bcast),
        .response_done     (response_done),
        .tx_exp_rp_start   (tx_exp_rp_start),
        .tx_06_rp_start    (tx_06_rp_start),
        .tx_03_04_rp_start (tx_03_04_rp_start),
        .busy              (busy),
        .sched_done        (sched_done),
        .overrun           (overrun),
        .wdog_to           (wdog_to)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int q_st_cyc[$];
    int q_st_kind[$];
    int q_sd[$];
    int q_ov[$];
    int q_wd[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_exp = 1'b0;
        req_06 = 1'b0;
        req_0304 = 1'b0;
        req_bcast = 1'b0;
        response_done = 1'b0;
    endtask

    // Event monitor: every output pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        int ak;
        if (tx_exp_rp_start || tx_06_rp_start || tx_03_04_rp_start) begin
            ak = tx_exp_rp_start ? 0 : (tx_06_rp_start ? 1 : 2);
            chk("start_onehot",
                $countones({tx_exp_rp_start, tx_06_rp_start,
                            tx_03_04_rp_start}), 1);
            if (q_st_cyc.size() == 0) begin
                chk("start_unexpected", cyc, -1);
            end else begin
                chk("start_cycle", cyc, q_st_cyc.pop_front());
                chk("start_kind", ak, q_st_kind.pop_front());
            end
        end
        if (sched_done) begin
            if (q_sd.size() == 0) chk("sched_done_unexpected", cyc, -1);
            else chk("sched_done_cycle", cyc, q_sd.pop_front());
        end
        if (overrun) begin
            if (q_ov.size() == 0) chk("overrun_unexpected", cyc, -1);
            else chk("overrun_cycle", cyc, q_ov.pop_front());
        end
        if (wdog_to) begin
            if (q_wd.size() == 0) chk("wdog_unexpected", cyc, -1);
            else chk("wdog_cycle", cyc, q_wd.pop_front());
        end
    end

    // mode 0: response after a short delay; 1: response on the watchdog
    // terminal cycle; 2: no response at all.
    task automatic txn(input logic [2:0] mask, input bit bc, input int mode);
        int k, s, r, ov, sp, endc, held;
        k = cyc;
        s = k + 1 + G;
        ov = -1;
        sp = -1;
        r = -1;
        held = -1;
        if (bc) begin
            q_sd.push_back(k + 1);
            endc = k + 1;
        end else begin
            q_st_cyc.push_back(s);
            q_st_kind.push_back(mask[2] ? 0 : (mask[1] ? 1 : 2));
            ov = k + int'($urandom_range(2, G + 20));
            sp = k + int'($urandom_range(2, G));
            if (mode == 0) begin
                r = s + int'($urandom_range(25, 60));
            end else if (mode == 1) begin
                r = s + WD;
            end else begin
`ifdef MODBUS_TX_WDOG_EN
                q_wd.push_back(s + WD);
                q_sd.push_back(s + WD);
                endc = s + WD;
`else
                held = s + WD + 40;
                r = s + WD + 50;
`endif
            end
            if (r >= 0) endc = r;
        end
        while (cyc <= endc) begin
            clear_in();
            if (cyc == k) begin
                {req_exp, req_06, req_0304} = mask;
                req_bcast = bc;
            end
            if (cyc == ov) begin
                {req_exp, req_06, req_0304} = 3'($urandom_range(1, 7));
                q_ov.push_back(cyc + 1);
            end
            if (cyc == sp || cyc == r) response_done = 1'b1;
            if (cyc == r) q_sd.push_back(cyc);
            if (cyc == k + 1) chk("busy_after_req", int'(busy), bc ? 0 : 1);
            if (cyc == held) chk("busy_held_no_wdog", int'(busy), 1);
            tick();
        end
        clear_in();
    endtask

    initial begin : timeout
        #(60000 * 10);
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin : driver
        int k;
        clear_in();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_sched_done", int'(sched_done), 0);
        chk("rst_starts",
            int'({tx_exp_rp_start, tx_06_rp_start, tx_03_04_rp_start}), 0);
        rst_n = 1'b1;
        tick();

        txn(3'b010, 1'b0, 0);
        txn(3'b101, 1'b0, 0);
        txn(3'b001, 1'b1, 0);
        txn(3'b111, 1'b1, 0);
        repeat (10) begin
            txn(3'($urandom_range(1, 7)), ($urandom_range(0, 3) == 0), 0);
        end
        txn(3'b010, 1'b0, 2);
        txn(3'b100, 1'b0, 1);

        k = cyc;
        req_06 = 1'b1;
        q_st_cyc.push_back(k + 1 + G);
        q_st_kind.push_back(1);
        tick();
        clear_in();
        repeat (100) tick();
        rst_n = 1'b0;
        #1;
        chk("midgap_rst_busy", int'(busy), 0);
        chk("midgap_rst_outs",
            int'({tx_exp_rp_start, tx_06_rp_start, tx_03_04_rp_start,
                  sched_done, overrun, wdog_to}), 0);
        void'(q_st_cyc.pop_back());
        void'(q_st_kind.pop_back());
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (G + 50) tick();
        chk("post_rst_idle", int'(busy), 0);

        txn(3'b001, 1'b0, 0);
        repeat (5) tick();

        chk("leftover_start", q_st_cyc.size(), 0);
        chk("leftover_sched_done", q_sd.size(), 0);
        chk("leftover_overrun", q_ov.size(), 0);
        chk("leftover_wdog", q_wd.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
